// File: rtl/counter_pkg.sv
// Shared definitions for the counter bank: direction encoding and the
// supported range of the channel-count and width parameters.
package counter_pkg;

  // Per-channel count direction as carried on the down[] input.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Supported parameter ranges for counter_bank.
  localparam int NCHAN_MIN = 1;
  localparam int NCHAN_MAX = 16;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage : counter_pkg

// File: rtl/counter_chan.sv
// One counter channel: input edge detector, modular up/down count register,
// and the combinational terminal-count / rollover outputs. The channel does
// not choose its own event source; the top level feeds the selected event
// back in on ev.
module counter_chan
  import counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cnt_in,
  input  logic             clr,
  input  logic             down,
  input  logic             ev,
  output logic             raw_edge,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             carry
);

  logic prev;
  dir_e dir;

  assign dir = dir_e'(down);

  // Track last cycle's cnt_in so a held-high input yields a single event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev <= 1'b0;
    end else begin
      prev <= cnt_in;
    end
  end

  // Rising edge of cnt_in relative to the previous cycle.
  assign raw_edge = cnt_in & ~prev;

  // Terminal count depends on direction: all-ones going up, zero going down.
  assign tc = (dir == DIR_DOWN) ? (count == '0) : (count == '1);

  // A rollover happens only when the event is actually applied; a clear
  // in the same cycle suppresses it.
  assign carry = ev & tc & ~clr;

  // Count register: reset, then clear, then the selected event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ev) begin
      if (dir == DIR_DOWN) begin
        count <= count - WIDTH'(1);
      end else begin
        count <= count + WIDTH'(1);
      end
    end
  end

endmodule : counter_chan

// File: rtl/counter_bank.sv
// Bank of NCHAN independent WIDTH-bit edge counters. Any channel above 0 can
// be cascaded onto the rollover of the channel below it; the rollover ripples
// combinationally so a whole chain advances within a single clock.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NCHAN = 2,
  parameter int WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NCHAN-1:0]       cnt_in,
  input  logic [NCHAN-1:0]       clr,
  input  logic [NCHAN-1:0]       cascade,
  input  logic [NCHAN-1:0]       down,
  output logic [NCHAN*WIDTH-1:0] count,
  output logic [NCHAN-1:0]       tc,
  output logic [NCHAN-1:0]       carry
);

  // Channel 0 has no lower neighbour, so its cascade select is never used.
  logic unused_cascade0;
  assign unused_cascade0 = cascade[0];

  for (genvar i = 0; i < NCHAN; i++) begin : gen_chan
    // Per-channel nets kept local to the generate scope so the carry chain
    // is a straight line of distinct signals from channel to channel.
    logic             ev;
    logic             raw_edge;
    logic             tc_w;
    logic             carry_w;
    logic [WIDTH-1:0] count_w;

    // Event source select: own input edge, or the rollover of channel i-1.
    if (i == 0) begin : gen_first
      assign ev = raw_edge;
    end else begin : gen_link
      assign ev = cascade[i] ? gen_chan[i-1].carry_w : raw_edge;
    end

    counter_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .cnt_in   (cnt_in[i]),
      .clr      (clr[i]),
      .down     (down[i]),
      .ev       (ev),
      .raw_edge (raw_edge),
      .count    (count_w),
      .tc       (tc_w),
      .carry    (carry_w)
    );

    assign count[i*WIDTH +: WIDTH] = count_w;
    assign tc[i]                   = tc_w;
    assign carry[i]                = carry_w;
  end

endmodule : counter_bank

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank at its default size (2 channels x 4 bits).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_counter_bank;

  localparam int NCHAN = 2;
  localparam int WIDTH = 4;

  logic                   clk;
  logic                   reset_n;
  logic [NCHAN-1:0]       cnt_in;
  logic [NCHAN-1:0]       clr;
  logic [NCHAN-1:0]       cascade;
  logic [NCHAN-1:0]       down;
  logic [NCHAN*WIDTH-1:0] count;
  logic [NCHAN-1:0]       tc;
  logic [NCHAN-1:0]       carry;

  int n_checks;
  int n_pass;
  int carry_hits0;
  int carry_hits1;
  int last_hit0;
  int pulse_num;
  logic [WIDTH-1:0] exp_q[$];

  counter_bank #(
    .NCHAN (NCHAN),
    .WIDTH (WIDTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cnt_in  (cnt_in),
    .clr     (clr),
    .cascade (cascade),
    .down    (down),
    .count   (count),
    .tc      (tc),
    .carry   (carry)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [WIDTH-1:0] ch_cnt(input int ch);
    return count[ch*WIDTH +: WIDTH];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    clr = '1;
    tick();
    clr = '0;
  endtask

  // One rise/fall on cnt_in[ch]; carry is sampled in the event cycle.
  task automatic pulse(input int ch);
    pulse_num++;
    cnt_in[ch] = 1'b1;
    #1;
    if (carry[0]) begin
      carry_hits0++;
      last_hit0 = pulse_num;
    end
    if (carry[1]) carry_hits1++;
    tick();
    cnt_in[ch] = 1'b0;
    tick();
  endtask

  task automatic pulses(input int ch, input int n);
    for (int k = 0; k < n; k++) pulse(ch);
  endtask

  task automatic reset_stats();
    carry_hits0 = 0;
    carry_hits1 = 0;
    last_hit0   = 0;
    pulse_num   = 0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset_stats();
    reset_n = 1'b0;
    cnt_in  = '0;
    clr     = '0;
    cascade = '0;
    down    = '0;

    // Reset state
    tick();
    tick();
    check("rst_count", 32'(count), 32'h00);
    check("rst_tc_up", 32'(tc), 32'h0);
    check("rst_carry", 32'(carry), 32'h0);
    down = 2'b11;
    #1;
    check("rst_tc_down", 32'(tc), 32'h3);
    down = 2'b00;
    reset_n = 1'b1;
    tick();

    // 17 pulses on ch0: one carry on the 16th, count ends at 1
    pulses(0, 17);
    check("up17_count0", 32'(ch_cnt(0)), 32'h1);
    check("up17_count1", 32'(ch_cnt(1)), 32'h0);
    check("up17_carry_n", 32'(carry_hits0), 32'd1);
    check("up17_carry_at", 32'(last_hit0), 32'd16);

    // Cascade ch1 on ch0
    clear_all();
    reset_stats();
    cascade = 2'b10;
    pulses(0, 16);
    check("casc16_ch0", 32'(ch_cnt(0)), 32'h0);
    check("casc16_ch1", 32'(ch_cnt(1)), 32'h1);
    pulses(0, 240);
    check("casc256_cnt", 32'(count), 32'h00);
    check("casc256_c1", 32'(carry_hits1), 32'd1);
    check("casc256_c0", 32'(carry_hits0), 32'd16);

    // Down count from zero
    clear_all();
    cascade = 2'b00;
    down = 2'b01;
    #1;
    check("dn_tc0", 32'(tc[0]), 32'h1);
    cnt_in[0] = 1'b1;
    #1;
    check("dn_carry0", 32'(carry[0]), 32'h1);
    tick();
    check("dn_count0", 32'(ch_cnt(0)), 32'hF);
    cnt_in[0] = 1'b0;
    down = 2'b00;
    tick();

    // Held high for 10 cycles counts once
    clear_all();
    cnt_in[0] = 1'b1;
    repeat (10) tick();
    check("hold_count0", 32'(ch_cnt(0)), 32'h1);
    cnt_in[0] = 1'b0;
    clear_all();

    // Toggling every cycle: one event per two cycles
    exp_q = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4};
    for (int k = 0; k < 8; k++) begin
      logic [WIDTH-1:0] e;
      cnt_in[0] = (k % 2 == 0);
      tick();
      e = exp_q.pop_front();
      check($sformatf("toggle_%0d", k), 32'(ch_cnt(0)), 32'(e));
    end
    cnt_in[0] = 1'b0;
    tick();

    // Clear on ch0 coincident with a cascade event: ch1 must not count
    clear_all();
    pulses(0, 15);
    pulses(1, 3);
    check("pre_clr_cnt", 32'(count), 32'h3F);
    cascade = 2'b10;
    cnt_in[0] = 1'b1;
    clr = 2'b01;
    #1;
    check("clr0_carry", 32'(carry), 32'h0);
    tick();
    check("clr0_cnt", 32'(count), 32'h30);
    cnt_in[0] = 1'b0;
    clr = 2'b00;
    tick();

    // Clear on ch1 coincident with incoming carry: clear wins
    pulses(0, 15);
    check("pre_clr1_cnt", 32'(count), 32'h3F);
    cnt_in[0] = 1'b1;
    clr = 2'b10;
    #1;
    check("clr1_carry0", 32'(carry[0]), 32'h1);
    tick();
    check("clr1_cnt", 32'(count), 32'h00);
    cnt_in[0] = 1'b0;
    clr = 2'b00;
    tick();

    // Cascade switch produces no event; raw edge ignored while cascaded
    cnt_in[1] = 1'b1;
    tick();
    check("casc_ign_raw", 32'(ch_cnt(1)), 32'h0);
    cascade = 2'b00;
    tick();
    check("casc_switch", 32'(ch_cnt(1)), 32'h0);
    cnt_in[1] = 1'b0;
    tick();

    // Direction change reflects on tc immediately
    #1;
    check("dir_tc_up", 32'(tc[0]), 32'h0);
    down[0] = 1'b1;
    #1;
    check("dir_tc_dn", 32'(tc[0]), 32'h1);
    down = 2'b00;

    // Reset in the middle of a full-chain ripple
    clear_all();
    cascade = 2'b10;
    pulses(0, 255);
    check("pre_rip_cnt", 32'(count), 32'hFF);
    cnt_in[0] = 1'b1;
    #1;
    check("rip_carry", 32'(carry), 32'h3);
    reset_n = 1'b0;
    tick();
    check("rip_rst_cnt", 32'(count), 32'h00);
    tick();
    check("rst_hi_cnt0", 32'(ch_cnt(0)), 32'h0);
    reset_n = 1'b1;
    tick();
    check("rel_cnt0", 32'(ch_cnt(0)), 32'h1);
    cnt_in[0] = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter_bank
